// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
//   WB_AW / WB_DW / WB_DEPTH : default address width, data width, FIFO depth
//   wb_entry_t               : one queued write {valid, waddr, wdata} at default widths
package regfile_wb_ctrl_pkg;

  localparam int unsigned WB_AW    = 4;
  localparam int unsigned WB_DW    = 64;
  localparam int unsigned WB_DEPTH = 4;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// Load-result FIFO for the writeback controller.
// Ports:
//   clk, reset                  clock, async active-high reset
//   push, push_waddr/wdata      enqueue request (ignored when full)
//   pop                         dequeue request (ignored when empty)
//   squash, squash_addr         clear valid of every entry (incl. same-cycle push) targeting squash_addr
//   head_valid/waddr/wdata      head entry contents
//   empty, full, count          occupancy
//   r0addr/r1addr, r0/r1_match  any valid entry targets the given address
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_waddr,
  input  logic [DW-1:0]            push_wdata,
  input  logic                     pop,
  input  logic                     squash,
  input  logic [AW-1:0]            squash_addr,
  output logic                     head_valid,
  output logic [AW-1:0]            head_waddr,
  output logic [DW-1:0]            head_wdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            r0addr,
  input  logic [AW-1:0]            r1addr,
  output logic                     r0_match,
  output logic                     r1_match
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_en;
  logic          pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign head_valid = mem_q[rd_ptr_q].valid;
  assign head_waddr = mem_q[rd_ptr_q].waddr;
  assign head_wdata = mem_q[rd_ptr_q].wdata;

  // Popped slots have their valid bit cleared so the match logic only ever
  // sees occupied, unsquashed entries. A squashed entry keeps its slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash && (mem_q[i].waddr == squash_addr)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (pop_en) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PW'(1);
      end
      if (push_en) begin
        mem_q[wr_ptr_q] <= '{valid: !(squash && (push_waddr == squash_addr)),
                              waddr: push_waddr,
                              wdata: push_wdata};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_comb begin
    r0_match = 1'b0;
    r1_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      r0_match = r0_match | (mem_q[i].valid && (mem_q[i].waddr == r0addr));
      r1_match = r1_match | (mem_q[i].valid && (mem_q[i].waddr == r1addr));
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller driving the single write port of the register file.
// ALU writes take fixed priority; load writes queue in wb_fifo.
// Ports:
//   clk, reset                     clock, async active-high reset
//   alu_valid/waddr/wdata          ALU write request (always accepted)
//   mem_valid/waddr/wdata, ready   load write request with handshake
//   wea, waddr, wdata              registered register-file write port
//   r0addr/r1addr, r0/r1_pending   decode read addresses and in-flight write flags
//   fifo_count                     load FIFO occupancy
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_waddr,
  input  logic [DW-1:0]          alu_wdata,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_waddr,
  input  logic [DW-1:0]          mem_wdata,
  output logic                   wea,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  input  logic [AW-1:0]          r0addr,
  input  logic [AW-1:0]          r1addr,
  output logic                   r0_pending,
  output logic                   r1_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic          fifo_empty;
  logic          fifo_full;
  logic          head_valid;
  logic [AW-1:0] head_waddr;
  logic [DW-1:0] head_wdata;
  logic          pop;
  logic          r0_match;
  logic          r1_match;

  assign mem_ready = !fifo_full;
  assign pop       = !alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (mem_valid),
    .push_waddr (mem_waddr),
    .push_wdata (mem_wdata),
    .pop        (pop),
    .squash     (alu_valid),
    .squash_addr(alu_waddr),
    .head_valid (head_valid),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count),
    .r0addr     (r0addr),
    .r1addr     (r1addr),
    .r0_match   (r0_match),
    .r1_match   (r1_match)
  );

  // A popped squashed entry still drives its address/data, just with wea=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wea   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (alu_valid) begin
      wea   <= 1'b1;
      waddr <= alu_waddr;
      wdata <= alu_wdata;
    end else if (!fifo_empty) begin
      wea   <= head_valid;
      waddr <= head_waddr;
      wdata <= head_wdata;
    end else begin
      wea   <= 1'b0;
    end
  end

  assign r0_pending = r0_match || (wea && (waddr == r0addr));
  assign r1_pending = r1_match || (wea && (waddr == r1addr));

endmodule
